// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit: state encoding, datapath
// width, instruction alignment mask and the default reset PC.
package pc_fetch_unit_pkg;

  localparam int              XLEN             = 32;
  localparam logic [1:0]      INSTR_ALIGN_MASK = 2'b11;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALTED
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] & INSTR_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack handshake between the fetch unit (master) and
// instruction memory (slave).
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/pc_fetch_unit_fetch_wait_timer.sv
// Counts cycles an outstanding fetch has waited; o_expired flags the cycle in
// which the wait reaches MAX_WAIT.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_count;

  // NOTE: state is written with <= only, so every flop samples pre-edge values
  // and simulation matches the synthesized registers regardless of block order.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && !i_clear && (r_count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the architectural PC, chooses PC+4 or a branch
// redirect, and runs the req/ack fetch toward instruction memory.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc_plus4_in,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              stall,
  pc_fetch_unit_if.master   imem,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   instr_out,
  output logic              instr_valid,
  output logic              misaligned,
  output logic              fetch_timeout
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_saved_target;
  logic            r_redirect_pending;
  logic            r_req;
  logic            r_valid;
  logic            r_misaligned;
  logic            r_timeout;

  logic w_ack;
  logic w_bad_target;
  logic w_wait_clear;
  logic w_wait_enable;
  logic w_wait_expired;

  assign w_ack         = imem.imem_ack;
  assign w_bad_target  = branch_taken && is_misaligned(branch_target);
  assign w_wait_enable = (r_state == REQ);
  assign w_wait_clear  = (r_state != REQ) || w_ack;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_wait_clear),
    .i_enable  (w_wait_enable),
    .o_expired (w_wait_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: r_saved_target stays out of reset; it is only consumed while
      // r_redirect_pending is set, and that flag is cleared here.
      r_state            <= IDLE;
      r_pc               <= RESET_PC;
      r_instr            <= '0;
      r_redirect_pending <= 1'b0;
      r_req              <= 1'b0;
      r_valid            <= 1'b0;
      r_misaligned       <= 1'b0;
      r_timeout          <= 1'b0;
    end else if (r_state != HALTED && w_bad_target) begin
      r_misaligned <= 1'b1;
      r_req        <= 1'b0;
      r_valid      <= 1'b0;
      r_state      <= HALTED;
    end else begin
      case (r_state)
        IDLE: begin
          if (branch_taken) r_pc <= branch_target;
          r_req   <= 1'b1;
          r_state <= REQ;
        end
        REQ: begin
          if (w_ack) begin
            // A branch arriving with the ack squashes that ack's data too.
            if (branch_taken || r_redirect_pending) begin
              r_pc               <= branch_taken ? branch_target : r_saved_target;
              r_redirect_pending <= 1'b0;
            end else begin
              r_instr <= imem.imem_rdata;
              r_valid <= 1'b1;
              r_pc    <= pc_plus4_in;
              r_req   <= 1'b0;
              r_state <= HOLD;
            end
          end else begin
            if (branch_taken) begin
              r_saved_target     <= branch_target;
              r_redirect_pending <= 1'b1;
            end
            if (w_wait_expired) begin
              r_timeout <= 1'b1;
              r_req     <= 1'b0;
              r_state   <= HALTED;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            r_pc    <= branch_target;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= REQ;
          end else if (!stall) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign pc_out         = r_pc;
  assign instr_out      = r_instr;
  assign instr_valid    = r_valid;
  assign misaligned     = r_misaligned;
  assign fetch_timeout  = r_timeout;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// run, all compared against a flag-based behavioural model of the fetch rules.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MAXW   = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_plus4_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        misaligned;
  logic        fetch_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pc_fetch_unit_if imem_if ();

  // Environment PC adder.
  assign pc_plus4_in = pc_out + 32'd4;

  pc_fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_plus4_in   (pc_plus4_in),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .imem          (imem_if),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .misaligned    (misaligned),
    .fetch_timeout (fetch_timeout)
  );

  // Behavioural model: booting / fetching / halted flags, holding otherwise.
  logic [31:0] m_pc, m_instr, m_saved;
  logic        m_valid, m_req, m_mis, m_to;
  logic        m_boot, m_fetching, m_halted, m_pend;
  int          m_waits;

  task automatic model_step();
    logic [31:0] next_seq;
    next_seq = m_pc + 32'd4;
    if (reset) begin
      m_pc = RST_PC; m_instr = '0; m_valid = 0; m_req = 0; m_mis = 0; m_to = 0;
      m_boot = 1; m_fetching = 0; m_halted = 0; m_pend = 0; m_waits = 0;
    end else if (m_halted) begin
    end else if (branch_taken && branch_target[1:0] != 2'b00) begin
      m_mis = 1; m_halted = 1; m_req = 0; m_valid = 0; m_fetching = 0; m_boot = 0;
    end else if (m_boot) begin
      m_boot = 0; m_fetching = 1; m_req = 1; m_waits = 0;
      if (branch_taken) m_pc = branch_target;
    end else if (m_fetching) begin
      if (imem_if.imem_ack) begin
        m_waits = 0;
        if (branch_taken) begin
          m_pc = branch_target; m_pend = 0;
        end else if (m_pend) begin
          m_pc = m_saved; m_pend = 0;
        end else begin
          m_instr = imem_if.imem_rdata; m_valid = 1; m_pc = next_seq;
          m_req = 0; m_fetching = 0;
        end
      end else begin
        if (branch_taken) begin
          m_saved = branch_target; m_pend = 1;
        end
        m_waits++;
        if (m_waits == MAXW) begin
          m_to = 1; m_halted = 1; m_req = 0; m_fetching = 0;
        end
      end
    end else begin
      if (branch_taken) begin
        m_pc = branch_target; m_valid = 0; m_req = 1; m_fetching = 1; m_waits = 0;
      end else if (!stall) begin
        m_valid = 0; m_req = 1; m_fetching = 1; m_waits = 0;
      end
    end
  endtask

  function automatic logic [99:0] dut_vec();
    return {imem_if.imem_req, imem_if.imem_addr, pc_out, instr_out,
            instr_valid, misaligned, fetch_timeout};
  endfunction

  function automatic logic [99:0] model_vec();
    return {m_req, m_pc, m_pc, m_instr, m_valid, m_mis, m_to};
  endfunction

  task automatic apply(input logic rst, input logic ack, input logic [31:0] rd,
                       input logic br, input logic [31:0] tgt, input logic stl);
    reset              = rst;
    imem_if.imem_ack   = ack;
    imem_if.imem_rdata = rd;
    branch_taken       = br;
    branch_target      = tgt;
    stall              = stl;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    apply(1, 0, 32'h0, 0, 32'h0, 0);
    apply(1, 1, 32'hFFFF_FFFF, 0, 32'h0, 1);
    total++;
    if ({pc_out, imem_if.imem_req, instr_out, instr_valid, misaligned, fetch_timeout}
        !== {RST_PC, 1'b0, 32'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_values: got pc=%h req=%b instr=%h v=%b mis=%b to=%b",
               pc_out, imem_if.imem_req, instr_out, instr_valid, misaligned, fetch_timeout);
    end
    apply(0, 0, 32'h0, 0, 32'h0, 0);
    total++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== RST_PC) begin
      bad++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h",
               imem_if.imem_req, imem_if.imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [2];
    exp_addr[0] = 32'h0;
    exp_addr[1] = 32'h4;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (imem_if.imem_addr !== exp_addr[k] || imem_if.imem_req !== 1'b1) begin
        bad++;
        $display("FAIL seq_addr: got %h req=%b want %h", imem_if.imem_addr,
                 imem_if.imem_req, exp_addr[k]);
      end
      apply(0, 1, NOP, 0, 32'h0, 0);
      total++;
      if (instr_valid !== 1'b1 || instr_out !== NOP || dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL seq_valid: got v=%b instr=%h dut=%h model=%h",
                 instr_valid, instr_out, dut_vec(), model_vec());
      end
      apply(0, 0, $urandom, 0, 32'h0, 0);
      total++;
      if (instr_valid !== 1'b0 || dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL seq_gap: got v=%b dut=%h model=%h", instr_valid, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_stall();
    total++;
    if (imem_if.imem_addr !== 32'h8) begin
      bad++;
      $display("FAIL stall_pre_addr: got %h want 00000008", imem_if.imem_addr);
    end
    apply(0, 1, NOP, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, $urandom_range(0, 1), $urandom, 0, 32'h0, 1);
      total++;
      if (instr_valid !== 1'b1 || pc_out !== 32'hC || instr_out !== NOP ||
          imem_if.imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: got v=%b pc=%h instr=%h req=%b want v=1 pc=0000000c instr=%h req=0",
                 instr_valid, pc_out, instr_out, imem_if.imem_req, NOP);
      end
    end
    apply(0, 0, 32'h0, 0, 32'h0, 0);
    total++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'hC || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: got req=%b addr=%h v=%b want req=1 addr=0000000c v=0",
               imem_if.imem_req, imem_if.imem_addr, instr_valid);
    end
    apply(0, 1, NOP, 0, 32'h0, 0);
    apply(0, 0, 32'h0, 0, 32'h0, 0);
    total++;
    if (dut_vec() !== model_vec() || imem_if.imem_addr !== 32'h10) begin
      bad++;
      $display("FAIL stall_next: dut=%h model=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_branch_pending();
    apply(0, 0, $urandom, 1, 32'h100, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_if.imem_addr !== 32'h10 || imem_if.imem_req !== 1'b1) begin
        bad++;
        $display("FAIL pend_addr_stable: got addr=%h req=%b want 00000010 req=1",
                 imem_if.imem_addr, imem_if.imem_req);
      end
      if (i < 3) apply(0, 0, $urandom, 0, 32'h0, 0);
    end
    apply(0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    total++;
    if (instr_valid !== 1'b0 || pc_out !== 32'h100 || imem_if.imem_req !== 1'b1) begin
      bad++;
      $display("FAIL pend_discard: got v=%b pc=%h req=%b want v=0 pc=00000100 req=1",
               instr_valid, pc_out, imem_if.imem_req);
    end
    apply(0, 1, NOP, 0, 32'h0, 0);
    total++;
    if (instr_valid !== 1'b1 || instr_out !== NOP || pc_out !== 32'h104) begin
      bad++;
      $display("FAIL pend_refetch: got v=%b instr=%h pc=%h want v=1 instr=%h pc=00000104",
               instr_valid, instr_out, pc_out, NOP);
    end
    apply(0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic test_misaligned();
    apply(0, 0, $urandom, 1, 32'h102, 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (misaligned !== 1'b1 || imem_if.imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          pc_out !== 32'h104) begin
        bad++;
        $display("FAIL misaligned_halt: got mis=%b req=%b v=%b pc=%h want 1 0 0 00000104",
                 misaligned, imem_if.imem_req, instr_valid, pc_out);
      end
      apply(0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
    end
  endtask

  task automatic test_timeout();
    apply(1, 0, 32'h0, 0, 32'h0, 0);
    apply(0, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 1; i <= MAXW; i++) begin
      apply(0, 0, $urandom, 0, 32'h0, 0);
      total++;
      if (fetch_timeout !== (i == MAXW) || imem_if.imem_req !== (i != MAXW)) begin
        bad++;
        $display("FAIL timeout_cycle%0d: got to=%b req=%b want to=%b req=%b",
                 i, fetch_timeout, imem_if.imem_req, (i == MAXW), (i != MAXW));
      end
    end
    apply(0, 1, NOP, 1, 32'h40, 0);
    apply(0, 0, NOP, 0, 32'h0, 0);
    total++;
    if (dut_vec() !== model_vec() || fetch_timeout !== 1'b1 || imem_if.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_hold: dut=%h model=%h", dut_vec(), model_vec());
    end
    apply(1, 0, 32'h0, 0, 32'h0, 0);
    total++;
    if (fetch_timeout !== 1'b0 || misaligned !== 1'b0 || pc_out !== RST_PC) begin
      bad++;
      $display("FAIL timeout_reset: got to=%b mis=%b pc=%h", fetch_timeout, misaligned, pc_out);
    end
    apply(0, 0, 32'h0, 0, 32'h0, 0);
    total++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== RST_PC) begin
      bad++;
      $display("FAIL timeout_refetch: got req=%b addr=%h want req=1 addr=%h",
               imem_if.imem_req, imem_if.imem_addr, RST_PC);
    end
  endtask

  task automatic test_wrap_and_branch_stall();
    apply(0, 1, NOP, 0, 32'h0, 0);
    apply(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
    total++;
    if (instr_valid !== 1'b0 || imem_if.imem_req !== 1'b1 || pc_out !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL branch_over_stall: got v=%b req=%b pc=%h want v=0 req=1 pc=fffffffc",
               instr_valid, imem_if.imem_req, pc_out);
    end
    apply(0, 1, NOP, 0, 32'h0, 0);
    total++;
    if (pc_out !== 32'h0 || instr_valid !== 1'b1 || misaligned !== 1'b0 || fetch_timeout !== 1'b0) begin
      bad++;
      $display("FAIL pc_wrap: got pc=%h v=%b mis=%b to=%b want pc=00000000 v=1 mis=0 to=0",
               pc_out, instr_valid, misaligned, fetch_timeout);
    end
    apply(0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic test_random();
    int          ack_pct;
    int          errs;
    logic        rst, ack, br;
    logic [31:0] tgt;
    ack_pct = 50;
    errs    = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0:       ack_pct = 0;
          1:       ack_pct = 40;
          2:       ack_pct = 80;
          default: ack_pct = 100;
        endcase
      end
      rst = (m_halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
      ack = ($urandom_range(0, 99) < ack_pct);
      br  = ($urandom_range(0, 7) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFFC;
      apply(rst, ack, $urandom, br, tgt, $urandom_range(0, 2) == 0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL rand_cycle%0d: dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    branch_taken       = 1'b0;
    branch_target      = '0;
    stall              = 1'b0;
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_pending();
    test_misaligned();
    test_timeout();
    test_wrap_and_branch_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer side of the PC+4 path.
- Holds the architectural PC and selects the next PC from the sequential PC+4 input or a branch redirect.
- Runs a req/ack fetch handshake with instruction memory and presents fetched instructions to decode.
- Sits between the PC+4 adder, the execute-stage branch resolution and the instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 8, maximum cycles a fetch may wait for imem_ack before timeout (must be >= 1).

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- pc_plus4_in  input  32  PC+4 of pc_out, from the PC adder.
- branch_taken  input  1  redirect request from execute, single-cycle pulse.
- branch_target  input  32  redirect address, valid when branch_taken=1.
- stall  input  1  decode cannot accept instr_out this cycle.
- imem_ack  input  1  instruction memory has returned data for imem_addr.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, equal to pc_out.
- pc_out  output  32  current PC, fed to the PC adder.
- instr_out  output  32  fetched instruction to decode.
- instr_valid  output  1  instr_out holds a valid instruction.
- misaligned  output  1  sticky, set when a redirect target has bits [1:0] != 0.
- fetch_timeout  output  1  sticky, set when a fetch waits MAX_WAIT cycles without imem_ack.

Behaviour:
- Reset values:
  - pc_out=RESET_PC, imem_req=0, instr_out=0, instr_valid=0, misaligned=0, fetch_timeout=0.
  - Wait counter=0, redirect_pending=0, state=IDLE.
  - Reset mid-fetch abandons the outstanding request with no further outputs from it.
- States:
  - IDLE: one cycle after reset, then go to REQ.
  - REQ: imem_req=1, imem_addr=pc_out. pc_out and imem_addr stay stable until imem_ack.
  - HOLD: instr_valid=1, stays here while stall=1.
  - HALTED: imem_req=0, instr_valid=0. Exit only via reset.
- REQ with imem_ack=1:
  - If redirect_pending=0: instr_out<=imem_rdata, instr_valid<=1, pc_out<=pc_plus4_in, go to HOLD.
  - If redirect_pending=1: discard the data, pc_out<=saved target, clear redirect_pending, stay in REQ (new request next cycle).
- REQ without imem_ack:
  - Wait counter increments each cycle.
  - When the counter reaches MAX_WAIT: fetch_timeout<=1, go to HALTED.
  - Counter clears on every ack and on every entry to REQ.
- HOLD:
  - If stall=0: instr_valid<=0, go to REQ with the already-updated pc_out. This gives one instruction per 2 cycles with a 1-cycle ack.
  - If stall=1: instr_out, instr_valid and pc_out are all held.
- branch_taken=1 handling:
  - In HOLD, or in IDLE: pc_out<=branch_target, instr_valid<=0, go to REQ. The instruction being held is squashed.
  - In REQ without imem_ack: save branch_target, set redirect_pending=1. The request is never withdrawn mid-handshake.
  - In REQ in the same cycle as imem_ack: treat as redirect_pending=1 for that ack. The data is discarded and pc_out<=branch_target.
  - branch_taken together with stall=1: branch wins and stall is ignored.
  - Second branch_taken while redirect_pending=1: the newest target overwrites the saved one.
- Alignment:
  - If branch_taken=1 and branch_target[1:0]!=0: misaligned<=1, go to HALTED, pc_out unchanged.
  - This check has priority over all other events in that cycle.
- Arithmetic:
  - No internal adder for sequential flow; pc_plus4_in is used as-is.
  - Wrap-around 32'hFFFF_FFFC -> 32'h0000_0000 is legal and not flagged.
- Inputs in HALTED are ignored.

Decomposition:
- Shared package holds:
  - State encoding enum: IDLE, REQ, HOLD, HALTED.
  - Constants XLEN=32 and INSTR_ALIGN_MASK=2'b11.
  - RESET_PC default value.
- One natural sub-module: fetch_wait_timer, a MAX_WAIT counter with clear, enable and expired outputs.
- The FSM, PC register and redirect buffer stay in pc_fetch_unit.

Test Plan:
- Reset then ack every request 1 cycle later, imem_rdata=32'h00000013 -> imem_addr sequence 0,4,8,C; instr_valid pulses once per 2 cycles with instr_out=32'h00000013.
- Stall held for 3 cycles while in HOLD at PC 8 -> instr_out, instr_valid=1 and pc_out=C stay constant; next request is issued to C after stall drops.
- branch_taken with target 32'h100 while in REQ, ack delayed 3 cycles -> imem_addr stays at the old PC until ack; that data never reaches instr_valid; next request goes to 32'h100.
- branch_taken with target 32'h102 -> misaligned=1, state HALTED, imem_req=0; both hold until reset.
- No ack for MAX_WAIT=8 cycles -> fetch_timeout=1 on cycle 8, imem_req deasserts, HALTED; reset clears everything and the next fetch goes to RESET_PC.
- pc_out=32'hFFFF_FFFC with pc_plus4_in=0, ack -> pc_out becomes 0 with no flag; branch_taken together with stall=1 in HOLD -> redirect taken.
